// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg -- shared definitions for the pipe_stage_reg slice.
//   pipe_state_e     : occupancy state of the stage (EMPTY / FULL / SKID)
//   PIPE_CNT_W       : width of the live-entry count output
//   pipe_state_count : maps an occupancy state to its live-entry count
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned PIPE_CNT_W = 2;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_FULL  = 2'd1,
        PIPE_SKID  = 2'd2
    } pipe_state_e;

    // Number of live entries held in a given state.
    function automatic logic [PIPE_CNT_W-1:0] pipe_state_count(input pipe_state_e st);
        logic [PIPE_CNT_W-1:0] cnt;
        case (st)
            PIPE_EMPTY: cnt = 2'd0;
            PIPE_FULL:  cnt = 2'd1;
            PIPE_SKID:  cnt = 2'd2;
            default:    cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// -----------------------------------------------------------------------------
// pipe_data_reg -- WIDTH-bit payload register with load enable and
// synchronous active-high reset to RST_VAL. Reset has priority over load.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   load : capture d at the next edge
//   d    : next payload
//   q    : held payload
// -----------------------------------------------------------------------------
module pipe_data_reg #(
    parameter int unsigned          WIDTH   = 32,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-value selection: load new payload or hold.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end else begin
            data_d = data_q;
        end
    end

    // Payload storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg -- valid/ready pipeline register stage.
// Build option: define PIPE_STAGE_SKID_EN to add a skid slot (two entries,
// in_ready has no combinational dependence on out_ready). Without it the stage
// is a single register whose in_ready looks through out_ready.
//   cpu_clk   : clock, all state updates on the rising edge
//   cpu_rst   : synchronous active-high reset
//   flush     : drop all held entries at the next edge
//   suspend   : block acceptance (draining continues)
//   in_valid  / in_ready  / in_data  : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and payload
//   count     : live entries (0..2 with skid, 0..1 without)
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  flush,
    input  logic                  suspend,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [PIPE_CNT_W-1:0] count
);

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             in_ready_s;
    logic             accept_s;
    logic             pop_s;
    logic             main_load_s;
    logic [WIDTH-1:0] main_d_s;
    logic [WIDTH-1:0] main_q;

    assign accept_s = in_valid & in_ready_s;
    assign pop_s    = out_valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic                  skid_load_s;
    logic [WIDTH-1:0]      skid_q;
    logic [PIPE_CNT_W-1:0] count_q;
    logic [PIPE_CNT_W-1:0] count_d;

    // Ready depends only on registered state; reset also blocks acceptance.
    assign in_ready_s = ~cpu_rst & ~suspend & ~flush & (state_q != PIPE_SKID);

    // Next-state and slot-load decode for the skid variant.
    always_comb begin
        state_d     = state_q;
        main_load_s = 1'b0;
        skid_load_s = 1'b0;
        main_d_s    = in_data;
        if (flush) begin
            state_d = PIPE_EMPTY;
        end else begin
            case (state_q)
                PIPE_EMPTY: begin
                    if (accept_s) begin
                        state_d     = PIPE_FULL;
                        main_load_s = 1'b1;
                    end else begin
                        state_d = PIPE_EMPTY;
                    end
                end
                PIPE_FULL: begin
                    if (accept_s && pop_s) begin
                        state_d     = PIPE_FULL;
                        main_load_s = 1'b1;
                    end else if (accept_s) begin
                        state_d     = PIPE_SKID;
                        skid_load_s = 1'b1;
                    end else if (pop_s) begin
                        state_d = PIPE_EMPTY;
                    end else begin
                        state_d = PIPE_FULL;
                    end
                end
                PIPE_SKID: begin
                    // Skid entry is the next-oldest; it moves into main on pop.
                    if (pop_s) begin
                        state_d     = PIPE_FULL;
                        main_load_s = 1'b1;
                        main_d_s    = skid_q;
                    end else begin
                        state_d = PIPE_SKID;
                    end
                end
                default: begin
                    state_d = PIPE_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != PIPE_EMPTY);
        count_d     = pipe_state_count(state_d);
    end

    // Occupancy state, valid and count registers.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q     <= PIPE_EMPTY;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    pipe_data_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_skid_reg (
        .clk  (cpu_clk),
        .rst  (cpu_rst),
        .load (skid_load_s),
        .d    (in_data),
        .q    (skid_q)
    );

    assign count = count_q;
`else
    // A full stage can accept only when its entry leaves in the same cycle.
    assign in_ready_s = ~cpu_rst & ~suspend & ~flush & (~out_valid_q | out_ready);

    // Next-state and load decode for the single-register variant.
    always_comb begin
        state_d     = state_q;
        main_load_s = 1'b0;
        main_d_s    = in_data;
        if (flush) begin
            state_d = PIPE_EMPTY;
        end else begin
            case (state_q)
                PIPE_EMPTY: begin
                    if (accept_s) begin
                        state_d     = PIPE_FULL;
                        main_load_s = 1'b1;
                    end else begin
                        state_d = PIPE_EMPTY;
                    end
                end
                PIPE_FULL: begin
                    // Accept while full implies a same-cycle pop.
                    if (accept_s) begin
                        state_d     = PIPE_FULL;
                        main_load_s = 1'b1;
                    end else if (pop_s) begin
                        state_d = PIPE_EMPTY;
                    end else begin
                        state_d = PIPE_FULL;
                    end
                end
                default: begin
                    state_d = PIPE_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != PIPE_EMPTY);
    end

    // Occupancy state and valid registers.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q     <= PIPE_EMPTY;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    // At most one entry, so the count is the registered valid bit.
    assign count = {1'b0, out_valid_q};
`endif

    pipe_data_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_main_reg (
        .clk  (cpu_clk),
        .rst  (cpu_rst),
        .load (main_load_s),
        .d    (main_d_s),
        .q    (main_q)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg -- directed bench for pipe_stage_reg (WIDTH=32, RST_VAL=0).
// Works for both builds; expectations that differ are selected by SKID_MODE.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID_MODE = 1'b1;
`else
    localparam bit SKID_MODE = 1'b0;
`endif

    logic        cpu_clk;
    logic        cpu_rst;
    logic        flush;
    logic        suspend;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;

    int n_checks;
    int n_fail;

    pipe_stage_reg #(
        .WIDTH   (32),
        .RST_VAL (32'h0)
    ) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .flush     (flush),
        .suspend   (suspend),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct packed {
        logic        rst;
        logic        fl;
        logic        sus;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic [31:0] exp_od;
        logic [1:0]  exp_cnt;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic sus,
                         input logic iv, input logic [31:0] d, input logic ordy);
        cpu_rst   = rst;
        flush     = fl;
        suspend   = sus;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    logic [31:0] src [3];
    int          sp;
    int          rp;
    int          budget;
    logic        acc;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;

        //           rst   fl    sus   iv    data         ordy  ir    ov    od           cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0,       2'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 32'h0,       2'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h11,      1'b1, 1'b1, 1'b1, 32'h11,      2'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h22,      1'b1, 1'b1, 1'b1, 32'h22,      2'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h33,      1'b1, 1'b1, 1'b1, 32'h33,      2'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 32'h33,      2'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h5A,      1'b0, 1'b1, 1'b1, 32'h5A,      2'd1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h77,      1'b1, 1'b0, 1'b0, 32'h5A,      2'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h77,      1'b1, 1'b0, 1'b0, 32'h5A,      2'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h77,      1'b0, 1'b1, 1'b1, 32'h77,      2'd1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h88,      1'b1, 1'b0, 1'b0, 32'h77,      2'd0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h99,      1'b0, 1'b0, 1'b0, 32'h0,       2'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h44,      1'b0, 1'b1, 1'b1, 32'h44,      2'd1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h45,      1'b1, 1'b0, 1'b0, 32'h0,       2'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 32'h0,       2'd0};

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].sus, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d in_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].exp_ir});
            tick();
            check($sformatf("vec%0d out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_ov});
            check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_od);
            check($sformatf("vec%0d count", i), {30'h0, count}, {30'h0, vecs[i].exp_cnt});
        end

        // Backpressure: offer A1..A3 with out_ready low, then drain in order.
        src[0] = 32'hA1;
        src[1] = 32'hA2;
        src[2] = 32'hA3;
        sp = 0;
        rp = 0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, src[sp], 1'b0);
            #1;
            if (c == 0) begin
                check("bp in_ready c0", {31'h0, in_ready}, 32'h1);
            end else if (c == 1) begin
                check("bp in_ready c1", {31'h0, in_ready}, {31'h0, SKID_MODE});
            end else begin
                check("bp in_ready c2", {31'h0, in_ready}, 32'h0);
            end
            acc = in_valid & in_ready;
            tick();
            if (acc) sp++;
        end
        check("bp count held", {30'h0, count}, SKID_MODE ? 32'd2 : 32'd1);
        check("bp out_data held", out_data, 32'hA1);
        check("bp accepted", sp, SKID_MODE ? 32'd2 : 32'd1);
        #1;
        check("bp in_ready full", {31'h0, in_ready}, 32'h0);

        budget = 0;
        while (rp < 3 && budget < 20) begin
            drive(1'b0, 1'b0, 1'b0, (sp < 3), (sp < 3) ? src[sp] : 32'h0, 1'b1);
            #1;
            acc = in_valid & in_ready;
            if (out_valid) begin
                check($sformatf("bp drain %0d", rp), out_data, src[rp]);
                rp++;
            end
            tick();
            if (acc) sp++;
            budget++;
        end
        check("bp drained all", rp, 32'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        check("bp empty count", {30'h0, count}, 32'd0);

        // Flush while holding entries with a same-cycle offer.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hB1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hB2, 1'b0);
        tick();
        check("fl pre count", {30'h0, count}, SKID_MODE ? 32'd2 : 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hB3, 1'b1);
        #1;
        check("fl in_ready", {31'h0, in_ready}, 32'h0);
        tick();
        check("fl count", {30'h0, count}, 32'd0);
        check("fl out_valid", {31'h0, out_valid}, 32'h0);
        check("fl data kept", out_data, 32'hB1);

        // Reset together with flush while holding an entry.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hC1, 1'b0);
        tick();
        check("rf pre valid", {31'h0, out_valid}, 32'h1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hC2, 1'b1);
        tick();
        check("rf out_valid", {31'h0, out_valid}, 32'h0);
        check("rf out_data", out_data, 32'h0);
        check("rf count", {30'h0, count}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        check("rf in_ready after", {31'h0, in_ready}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter WIDTH, default 32, meaning payload bit width (1..256).
REQ-003 SHALL have parameter RST_VAL, default 0, meaning the out_data value after reset (WIDTH bits).
REQ-004 SHALL have port cpu_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port cpu_rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port flush  input  1  kill all held entries.
REQ-007 SHALL have port suspend  input  1  pipeline hold; blocks acceptance only.
REQ-008 SHALL have port in_valid  input  1  upstream offers payload.
REQ-009 SHALL have port in_ready  output  1  stage accepts payload this cycle.
REQ-010 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-011 SHALL have port out_valid  output  1  out_data holds a live entry.
REQ-012 SHALL have port out_ready  input  1  downstream takes the entry this cycle.
REQ-013 SHALL have port out_data  output  WIDTH  oldest live payload.
REQ-014 SHALL have port count  output  2  number of live entries (0..2).

Function
REQ-015 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready; each is one transfer per cycle.
REQ-016 SHALL drive in_ready = 0 whenever suspend=1 or flush=1, regardless of occupancy.
REQ-017 SHALL keep out_valid/out_data stable until pop; a suspend never drops or alters a held entry, and draining continues during suspend.
REQ-018 SHALL give accepted data 1-cycle latency: an entry accepted at edge N appears on out_data after edge N when the stage was empty.
REQ-019 SHALL preserve FIFO order; no entry is duplicated or lost except by flush or reset.
REQ-020 SHALL, on flush=1, clear all valids at the next edge (count=0), ignoring same-cycle accept and pop; data registers are not cleared.
REQ-021 SHALL, without skid, use states EMPTY and FULL with in_ready = !suspend & !flush & (!out_valid | out_ready), so accept and pop in the same cycle stays FULL.
REQ-022 SHALL, with skid, use states EMPTY, FULL and SKID, with in_ready = !suspend & !flush & (state != SKID), which has no combinational path from out_ready.
REQ-023 SHALL apply these skid transitions:
- EMPTY+accept -> FULL.
- FULL+accept&!pop -> SKID (new entry into skid slot).
- FULL+pop&!accept -> EMPTY.
- FULL+accept&pop -> FULL (new entry to main).
- SKID+pop -> FULL (skid slot moves to main in the same edge).
- Otherwise hold.
REQ-024 SHALL drive count = 0/1/2 for EMPTY/FULL/SKID, registered.

Reset
REQ-025 SHALL, when cpu_rst=1 at an edge, force state EMPTY, out_valid=0, count=0, out_data=RST_VAL and skid slot=RST_VAL.
REQ-026 SHALL let reset win over flush, accept and pop in the same cycle.
REQ-027 SHALL keep in_ready=0 during the reset cycle and allow acceptance from the first cycle after reset deasserts.

Configuration
REQ-028 SHALL compile the skid slot and SKID state in when macro PIPE_STAGE_SKID_EN is defined (REQ-022/023, count max 2).
REQ-029 SHALL, when PIPE_STAGE_SKID_EN is undefined, build a single register per REQ-021 with count max 1 and count[1] tied 0.

Structure
REQ-030 SHALL place the state typedef (PIPE_EMPTY, PIPE_FULL, PIPE_SKID) and the count width constant in shared package pipe_pkg.
REQ-031 SHALL instantiate sub-module pipe_data_reg (WIDTH-bit, load-enable, sync reset to RST_VAL) once for the main slot and once for the skid slot.

Verification
REQ-032 SHALL verify these directed cases (WIDTH=32, both macro settings):
- Reset: reset then idle -> out_valid=0, count=0, out_data=0, in_ready=1 the cycle after reset deasserts.
- Streaming: 0x11, 0x22, 0x33 in back-to-back with out_ready=1 -> same order on out_data, one per cycle, 1-cycle latency, count stays 1.
- Backpressure with skid: out_ready=0, offer 0xA1, 0xA2, 0xA3 -> count=2, in_ready=0, 0xA3 held upstream; then out_ready=1 -> 0xA1, 0xA2, 0xA3 in order.
- Backpressure without skid: same stimulus -> count=1, in_ready=0 while full, no loss.
- Suspend: suspend=1 with out_ready=1 and entry 0x5A held -> 0x5A drains, in_ready=0, in_data 0x77 not taken until suspend=0.
- Flush vs reset: flush with count=2 and in_valid=1 -> count=0 next cycle, nothing accepted; cpu_rst and flush together -> reset values.
